mc_main_control: RTL

//  Main control FSM for the multi-cycle MIPS datapath. Sequences fetch/decode/execute/memory/writeback
//  and drives every datapath enable: IR, PC, memory, ALU muxes, and the RegFile write port (RegWrite, RegDst, MemtoReg).

---
 rtl/mc_main_control.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mc_main_control.sv
`default_nettype none
// ============================================================================
// Module      : mc_main_control
// Description : Main control FSM of the multi-cycle MIPS datapath; sequences
//               fetch/decode/execute/memory/writeback with memory-ready stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       bad_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [1:0] c_srcb_b    = 2'b00;
  localparam logic [1:0] c_srcb_four = 2'b01;
  localparam logic [1:0] c_srcb_imm  = 2'b10;
  localparam logic [1:0] c_srcb_br   = 2'b11;

  state_t r_state;
  state_t w_next;
  logic   r_bad_op;
  logic   w_set_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_bad_op <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_bad) begin
        r_bad_op <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next      = S_FETCH;
    w_set_bad   = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = c_srcb_b;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;

    case (r_state)
      S_FETCH: begin
        // IR and PC load only in the cycle the instruction word arrives
        MemRead = 1'b1;
        ALUSrcB = c_srcb_four;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        w_next  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = c_srcb_br;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default: begin
            w_set_bad  = 1'b1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = c_srcb_imm;
        w_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        w_next     = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = c_srcb_imm;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      // encodings 12-15 drive nothing and recover to FETCH
      default: w_next = S_FETCH;
    endcase
  end

  assign bad_op = r_bad_op;
  assign state  = r_state;

endmodule
`default_nettype wire
